// File: rtl/game_tick_controller.sv
`default_nettype none
// ============================================================================
// Module      : game_tick_controller
// Description : Central timing scheduler for the game logic. Generates
//               NUM_CH independent one-cycle tick enables from the 100 MHz
//               board clock, each with its own programmable period. A small
//               FSM (STOPPED / RUNNING / STEPPING) sequences all channels,
//               and periods are written through a valid/ready handshake that
//               is only open while STOPPED.
//
// Parameters  : NUM_CH      - number of tick channels
//               DIV_W       - width of the period and counter registers
//               DEFAULT_DIV - reset period of every channel (clk_in cycles)
//
// Ports       : clk_in     in   board clock
//               reset_n    in   asynchronous active-low reset
//               run        in   level, 1 = run channels, 0 = stop
//               step       in   pulse, one tick on all enabled channels
//               cfg_valid  in   configuration request
//               cfg_ready  out  high while STOPPED (combinational)
//               cfg_ch     in   channel being configured
//               cfg_div    in   new period in cycles (0 is stored as 1)
//               cfg_en     in   channel enable written with the period
//               tick_o     out  registered one-cycle tick pulses
//               state_o    out  0 STOPPED, 1 RUNNING, 2 STEPPING
//               tick_count out  (GAME_TICK_COUNT_EN only) 16-bit wrapping
//                               pulse counter per channel, slice [16i+:16]
//
// Options     : define GAME_TICK_COUNT_EN to add the tick_count output.
//
// Revision    : 1.0 - initial release
// ============================================================================
module game_tick_controller #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 27,
    parameter int DEFAULT_DIV = 100000000
) (
    input  logic                       clk_in,
    input  logic                       reset_n,
    input  logic                       run,
    input  logic                       step,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [$clog2(NUM_CH)-1:0]  cfg_ch,
    input  logic [DIV_W-1:0]           cfg_div,
    input  logic                       cfg_en,
    output logic [NUM_CH-1:0]          tick_o,
    output logic [1:0]                 state_o
`ifdef GAME_TICK_COUNT_EN
    ,
    output logic [NUM_CH*16-1:0]       tick_count
`endif
);

    localparam int               c_ch_w      = $clog2(NUM_CH);
    localparam logic [DIV_W-1:0] c_one       = DIV_W'(1);
    localparam logic [DIV_W-1:0] c_div_reset = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] c_cnt_reset = DIV_W'(DEFAULT_DIV - 1);

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [DIV_W-1:0]    r_div [NUM_CH];
    logic [DIV_W-1:0]    r_cnt [NUM_CH];
    logic [NUM_CH-1:0]   r_en;
    logic [NUM_CH-1:0]   r_tick;

    logic                w_xfer;
    logic [DIV_W-1:0]    w_div_store;
    logic [NUM_CH-1:0]   w_sel;

    // ------------------------------------------------------------------
    // Config handshake. A period of 0 would make the div-1 reload wrap,
    // so it is stored as 1 (tick every running cycle). An out-of-range
    // channel number matches no w_sel bit and is therefore a no-op.
    // ------------------------------------------------------------------
    assign cfg_ready   = (r_state == ST_STOPPED);
    assign w_xfer      = cfg_valid && cfg_ready;
    assign w_div_store = (cfg_div == '0) ? c_one : cfg_div;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_sel[i] = w_xfer && (cfg_ch == c_ch_w'(i));
        end
    end

    // ------------------------------------------------------------------
    // FSM. Run has priority over step; STEPPING always lasts one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_STOPPED;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_STOPPED: begin
                if (run) begin
                    w_next = ST_RUNNING;
                end else if (step) begin
                    w_next = ST_STEPPING;
                end
            end
            ST_RUNNING: begin
                if (!run) begin
                    w_next = ST_STOPPED;
                end
            end
            ST_STEPPING: begin
                w_next = ST_STOPPED;
            end
            default: begin
                w_next = ST_STOPPED;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Channel datapath. Counters only move in RUNNING, so stopping and
    // resuming preserves each channel's phase. Config writes can only
    // land in STOPPED because cfg_ready is tied to that state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i] <= c_div_reset;
                r_cnt[i] <= c_cnt_reset;
            end
            r_en   <= '1;
            r_tick <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_tick[i] <= 1'b0;
                case (r_state)
                    ST_STOPPED: begin
                        if (w_sel[i]) begin
                            r_div[i] <= w_div_store;
                            r_cnt[i] <= w_div_store - c_one;
                            r_en[i]  <= cfg_en;
                        end
                    end
                    ST_RUNNING: begin
                        if (r_en[i]) begin
                            if (r_cnt[i] == '0) begin
                                r_cnt[i]  <= r_div[i] - c_one;
                                r_tick[i] <= 1'b1;
                            end else begin
                                r_cnt[i] <= r_cnt[i] - c_one;
                            end
                        end
                    end
                    ST_STEPPING: begin
                        r_tick[i] <= r_en[i];
                        if (r_en[i]) begin
                            r_cnt[i] <= r_div[i] - c_one;
                        end
                    end
                    default: begin
                        r_tick[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tick_o  = r_tick;
    assign state_o = r_state;

`ifdef GAME_TICK_COUNT_EN
    // Counts registered pulses (one cycle behind tick_o). A config write
    // to a channel clears its count and takes priority over a pending
    // increment in the same cycle.
    logic [NUM_CH*16-1:0] r_tick_count;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_count <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_sel[i]) begin
                    r_tick_count[16*i +: 16] <= 16'd0;
                end else if (r_tick[i]) begin
                    r_tick_count[16*i +: 16] <= r_tick_count[16*i +: 16] + 16'd1;
                end
            end
        end
    end

    assign tick_count = r_tick_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_game_tick_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_tick_controller
// Description : Directed self-checking bench for game_tick_controller.
//               Main instance: 4 channels, reset period 8. A second
//               3-channel instance exercises an out-of-range cfg_ch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_tick_controller;

    logic        clk_in;
    logic        reset_n;
    logic        run;
    logic        step;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [26:0] cfg_div;
    logic        cfg_en;
    logic [3:0]  tick_o;
    logic [1:0]  state_o;
`ifdef GAME_TICK_COUNT_EN
    logic [63:0] tick_count;
`endif

    logic        b_run;
    logic        b_step;
    logic        b_cfg_valid;
    logic        b_cfg_ready;
    logic [1:0]  b_cfg_ch;
    logic [26:0] b_cfg_div;
    logic        b_cfg_en;
    logic [2:0]  b_tick_o;
    logic [1:0]  b_state_o;
`ifdef GAME_TICK_COUNT_EN
    logic [47:0] b_tick_count;
`endif

    int n_vec;
    int n_fail;
    int n_p0;
    int n_p1;

    game_tick_controller #(
        .NUM_CH      (4),
        .DIV_W       (27),
        .DEFAULT_DIV (8)
    ) u_dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .run        (run),
        .step       (step),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_en     (cfg_en),
        .tick_o     (tick_o),
        .state_o    (state_o)
`ifdef GAME_TICK_COUNT_EN
        ,
        .tick_count (tick_count)
`endif
    );

    game_tick_controller #(
        .NUM_CH      (3),
        .DIV_W       (27),
        .DEFAULT_DIV (8)
    ) u_dut_b (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .run        (b_run),
        .step       (b_step),
        .cfg_valid  (b_cfg_valid),
        .cfg_ready  (b_cfg_ready),
        .cfg_ch     (b_cfg_ch),
        .cfg_div    (b_cfg_div),
        .cfg_en     (b_cfg_en),
        .tick_o     (b_tick_o),
        .state_o    (b_state_o)
`ifdef GAME_TICK_COUNT_EN
        ,
        .tick_count (b_tick_count)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [26:0] div, input logic en);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = div;
        cfg_en    = en;
        chk("cfg_ready_before_write", 32'(cfg_ready), 32'd1);
        cyc(1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_fail = 0; n_p0 = 0; n_p1 = 0;
        reset_n = 1'b0; run = 1'b0; step = 1'b0;
        cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 27'd0; cfg_en = 1'b0;
        b_run = 1'b0; b_step = 1'b0; b_cfg_valid = 1'b0;
        b_cfg_ch = 2'd0; b_cfg_div = 27'd0; b_cfg_en = 1'b0;

        // ---------------- reset state ----------------
        #1;
        chk("rst_tick", 32'(tick_o), 32'h0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        cyc(2);
        reset_n = 1'b1;

        // ---------------- reset mid-run ----------------
        run = 1'b1;
        cyc(1);
        chk("mr_state_run", 32'(state_o), 32'd1);
        cyc(7);
        chk("mr_tick_before", 32'(tick_o), 32'h0);
        cyc(1);
        chk("mr_tick_default8", 32'(tick_o), 32'hF);
        reset_n = 1'b0;
        #1;
        chk("mr_async_tick", 32'(tick_o), 32'h0);
        chk("mr_async_state", 32'(state_o), 32'd0);
        chk("mr_async_ready", 32'(cfg_ready), 32'd1);
        run = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        cyc(1);

        // ---------------- two channels, 24 running cycles ----------------
        cfg(2'd0, 27'd4, 1'b1);
        cfg(2'd1, 27'd6, 1'b1);
        run = 1'b1;
        cyc(1);
        chk("run_enter_tick", 32'(tick_o), 32'h0);
        for (int k = 1; k <= 24; k++) begin
            cyc(1);
            chk($sformatf("run24_k%0d", k), 32'(tick_o[1:0]),
                {30'd0, (k % 6 == 0), (k % 4 == 0)});
            if (tick_o[0]) n_p0++;
            if (tick_o[1]) n_p1++;
        end
        chk("run24_ch0_pulses", 32'(n_p0), 32'd6);
        chk("run24_ch1_pulses", 32'(n_p1), 32'd4);
        run = 1'b0;
        cyc(1);
        chk("run24_stopped", 32'(state_o), 32'd0);

        // ---------------- pause / resume ----------------
        cfg(2'd0, 27'd4, 1'b1);
        run = 1'b1;
        cyc(2);
        run = 1'b0;
        cyc(1);
        chk("pause_state", 32'(state_o), 32'd0);
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            chk("pause_no_tick", 32'(tick_o[0]), 32'd0);
        end
        run = 1'b1;
        cyc(2);
        chk("resume_tick_early", 32'(tick_o[0]), 32'd0);
        cyc(1);
        chk("resume_tick_2", 32'(tick_o[0]), 32'd1);
        run = 1'b0;
        cyc(2);
        chk("resume_stopped", 32'(state_o), 32'd0);

        // ---------------- single step ----------------
        cfg(2'd2, 27'd5, 1'b0);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("step_state", 32'(state_o), 32'd2);
        chk("step_tick_pre", 32'(tick_o), 32'h0);
        cyc(1);
        chk("step_tick", 32'(tick_o), 32'hB);
        chk("step_back_stop", 32'(state_o), 32'd0);
        cyc(1);
        chk("step_tick_clear", 32'(tick_o), 32'h0);

        // step + run together: run wins, step dropped
        run = 1'b1; step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("steprun_state", 32'(state_o), 32'd1);
        chk("steprun_no_tick", 32'(tick_o), 32'h0);
        cyc(3);
        chk("steprun_reload_quiet", 32'(tick_o), 32'h0);
        cyc(1);
        chk("steprun_ch0_reloaded", 32'(tick_o), 32'h1);
        run = 1'b0;
        cyc(1);
        chk("steprun_stopped", 32'(state_o), 32'd0);

        // ---------------- config blocked while running ----------------
        run = 1'b1;
        cyc(1);
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 27'd0; cfg_en = 1'b1;
        chk("blk_ready0", 32'(cfg_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("blk_ready_run", 32'(cfg_ready), 32'd0);
        end
        run = 1'b0;
        cyc(1);
        chk("blk_ready_stop", 32'(cfg_ready), 32'd1);
        cyc(1);
        cfg_valid = 1'b0;
        run = 1'b1;
        cyc(1);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("div0_every_cycle", 32'(tick_o[3]), 32'd1);
        end
        run = 1'b0;
        cyc(2);
        chk("div0_stop_tick", 32'(tick_o), 32'h0);

        // ---------------- out-of-range channel (3-channel instance) ------
        b_cfg_valid = 1'b1; b_cfg_ch = 2'd3; b_cfg_div = 27'd2; b_cfg_en = 1'b0;
        chk("oor_ready", 32'(b_cfg_ready), 32'd1);
        cyc(1);
        b_cfg_valid = 1'b0;
        b_run = 1'b1;
        cyc(8);
        chk("oor_no_change_early", 32'(b_tick_o), 32'h0);
        cyc(1);
        chk("oor_default_period", 32'(b_tick_o), 32'h7);
        b_run = 1'b0;
        cyc(1);

`ifdef GAME_TICK_COUNT_EN
        // ---------------- tick counter wrap ----------------
        cfg(2'd0, 27'd1, 1'b1);
        chk("cnt_cleared", 32'(tick_count[15:0]), 32'd0);
        run = 1'b1;
        cyc(1);
        cyc(65536);
        run = 1'b0;
        cyc(2);
        chk("cnt_wrap", 32'(tick_count[15:0]), 32'd1);
        cfg(2'd0, 27'd4, 1'b1);
        chk("cnt_cfg_clear", 32'(tick_count[15:0]), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
